sm_reator_multicanal: RTL and testbench

Parametrised multi-channel reactor safety supervisor: successor to the single-sensor reactor state machine. Votes N redundant over-temperature sensors on a sample strobe, escalates through cooling, concrete-door containment and audible alarm on configurable consecutive-sample thresholds, and de-escalates with hysteresis. The alarm is latched until operator acknowledge. Sits between the sensor conditioning front end and the plant actuator drivers.

---
 rtl/sm_reator_multicanal.sv | 150 +++++++++++++++
 tb/tb_sm_reator_multicanal.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sm_reator_multicanal.sv
//==============================================================================
// Module   : sm_reator_multicanal
// Brief    : Multi-channel reactor safety supervisor with sensor voting,
//            threshold escalation, hysteretic de-escalation and latched alarm.
// Revision : 1.0
//==============================================================================
`default_nettype none

module sm_reator_multicanal #(
    parameter int N_SENSORES  = 4,
    parameter int VOTOS       = 2,
    parameter int ALVO_REFRIG = 1,
    parameter int ALVO_PORTAS = 2,
    parameter int ALVO_ALARME = 3,
    parameter int ESFRIA      = 4
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic [N_SENSORES-1:0] S,
    input  logic                  amostra,
    input  logic                  reconhece,
    output logic                  sistemaRefrigeracao,
    output logic                  portasDeConcreto,
    output logic                  alarmeSonoroReator,
    output logic [2:0]            estado,
    output logic [4:0]            votosAtivos
);

    localparam logic [4:0] C_VOTOS  = 5'(VOTOS);
    localparam logic [7:0] C_REFRIG = 8'(ALVO_REFRIG);
    localparam logic [7:0] C_PORTAS = 8'(ALVO_PORTAS);
    localparam logic [7:0] C_ALARME = 8'(ALVO_ALARME);
    localparam logic [7:0] C_ESFRIA = 8'(ESFRIA);

    typedef enum logic [2:0] {
        REPOUSO      = 3'b000,
        REFRIGERANDO = 3'b001,
        CONTENCAO    = 3'b010,
        ALARME       = 3'b011,
        SILENCIADO   = 3'b100
    } estado_t;

    estado_t    state;
    estado_t    state_next;
    logic [7:0] cq;
    logic [7:0] cf;
    logic [7:0] cq_next;
    logic [7:0] cf_next;
    logic [7:0] h;
    logic [7:0] c;
    logic [4:0] votos;
    logic       hot;
    logic       cold;
    logic       step;

    always_comb begin
        votos = 5'd0;
        for (int i = 0; i < N_SENSORES; i++) begin
            votos = votos + 5'(S[i]);
        end
    end

    assign votosAtivos = votos;
    assign hot         = amostra && (votos >= C_VOTOS);
    assign cold        = amostra && (votos < C_VOTOS);

    // Streak lengths including the current sample, saturating at 255
    assign h = (cq == 8'hFF) ? 8'hFF : cq + 8'd1;
    assign c = (cf == 8'hFF) ? 8'hFF : cf + 8'd1;

    always_comb begin
        state_next = state;
        step       = 1'b0;
        case (state)
            REPOUSO: begin
                if (hot) begin
                    if (h >= C_ALARME)      state_next = ALARME;
                    else if (h >= C_PORTAS) state_next = CONTENCAO;
                    else if (h >= C_REFRIG) state_next = REFRIGERANDO;
                end
            end
            REFRIGERANDO: begin
                if (hot) begin
                    if (h >= C_ALARME)      state_next = ALARME;
                    else if (h >= C_PORTAS) state_next = CONTENCAO;
                end else if (cold && c >= C_ESFRIA) begin
                    state_next = REPOUSO;
                    step       = 1'b1;
                end
            end
            CONTENCAO: begin
                if (hot) begin
                    if (h >= C_ALARME) state_next = ALARME;
                end else if (cold && c >= C_ESFRIA) begin
                    state_next = REFRIGERANDO;
                    step       = 1'b1;
                end
            end
            ALARME: begin
                // Latched until acknowledged; cold samples never release it
                if (reconhece) state_next = SILENCIADO;
            end
            SILENCIADO: begin
                if (cold && c >= C_ESFRIA) begin
                    state_next = CONTENCAO;
                    step       = 1'b1;
                end
            end
            default: state_next = REPOUSO;
        endcase
    end

    always_comb begin
        cq_next = cq;
        cf_next = cf;
        if (hot) begin
            cq_next = h;
            cf_next = 8'd0;
        end else if (cold) begin
            cq_next = 8'd0;
            cf_next = step ? 8'd0 : c;
        end
    end

    // Outputs are decoded from the next state so they align with estado
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state               <= REPOUSO;
            cq                  <= 8'd0;
            cf                  <= 8'd0;
            sistemaRefrigeracao <= 1'b0;
            portasDeConcreto    <= 1'b0;
            alarmeSonoroReator  <= 1'b0;
        end else begin
            state               <= state_next;
            cq                  <= cq_next;
            cf                  <= cf_next;
            sistemaRefrigeracao <= (state_next != REPOUSO);
            portasDeConcreto    <= (state_next == CONTENCAO) ||
                                   (state_next == ALARME)    ||
                                   (state_next == SILENCIADO);
            alarmeSonoroReator  <= (state_next == ALARME);
        end
    end

    assign estado = state;

endmodule

`default_nettype wire

// File: tb/tb_sm_reator_multicanal.sv
//==============================================================================
// Module   : tb_sm_reator_multicanal
// Brief    : Scoreboard bench for sm_reator_multicanal with directed and
//            randomized sampling against a level-based reference model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_sm_reator_multicanal;

    localparam int N  = 4;
    localparam int VT = 2;
    localparam int AR = 1;
    localparam int AP = 2;
    localparam int AA = 3;
    localparam int ES = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] s   = '0;
    logic         am  = 1'b0;
    logic         ack = 1'b0;
    logic         refrig;
    logic         portas;
    logic         alarme;
    logic [2:0]   estado;
    logic [4:0]   votos;

    sm_reator_multicanal #(
        .N_SENSORES(N), .VOTOS(VT), .ALVO_REFRIG(AR),
        .ALVO_PORTAS(AP), .ALVO_ALARME(AA), .ESFRIA(ES)
    ) dut (
        .CLOCK(clk), .RESET(rst), .S(s), .amostra(am), .reconhece(ack),
        .sistemaRefrigeracao(refrig), .portasDeConcreto(portas),
        .alarmeSonoroReator(alarme), .estado(estado), .votosAtivos(votos)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] outs;
        logic [4:0] votos;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   active = 1'b0;
    bit   done   = 1'b0;

    // Reference model: level 0..3 is the escalation ladder, 4 is silenced alarm
    int m_lvl = 0;
    int m_cq  = 0;
    int m_cf  = 0;

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

    task automatic apply(input bit r, input bit a, input logic [N-1:0] sv, input bit k);
        exp_t e;
        int   n;
        bit   is_hot;
        int   hh;
        int   cc;
        int   tgt;
        bit   stepped;
        rst = r; am = a; s = sv; ack = k;
        n       = $countones(sv);
        is_hot  = a && (n >= VT);
        hh      = (m_cq + 1 > 255) ? 255 : m_cq + 1;
        cc      = (m_cf + 1 > 255) ? 255 : m_cf + 1;
        stepped = 1'b0;
        if (r) begin
            m_lvl = 0; m_cq = 0; m_cf = 0;
        end else begin
            if (m_lvl == 3 && k) begin
                m_lvl = 4;
            end else if (is_hot && m_lvl <= 2) begin
                tgt   = (hh >= AA) ? 3 : (hh >= AP) ? 2 : (hh >= AR) ? 1 : 0;
                m_lvl = max2(m_lvl, tgt);
            end else if (a && !is_hot && cc >= ES && m_lvl != 0 && m_lvl != 3) begin
                m_lvl   = (m_lvl == 4) ? 2 : m_lvl - 1;
                stepped = 1'b1;
            end
            if (a) begin
                if (is_hot) begin m_cq = hh; m_cf = 0; end
                else begin m_cq = 0; m_cf = stepped ? 0 : cc; end
            end
        end
        e.st    = 3'(m_lvl);
        e.outs  = {m_lvl != 0, m_lvl >= 2, m_lvl == 3};
        e.votos = 5'(n);
        q.push_back(e);
        active = 1'b1;
    endtask

    task automatic cyc(input bit r, input bit a, input logic [N-1:0] sv, input bit k, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            apply(r, a, sv, k);
        end
    endtask

    // Monitor: one expectation is consumed per rising edge once stimulus starts
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (active && !done) begin
                if (q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL scoreboard_underflow at %0t", $time);
                end else begin
                    e = q.pop_front();
                    checks++;
                    if (estado !== e.st) begin
                        errors++;
                        $display("FAIL estado at %0t: got %0d expected %0d", $time, estado, e.st);
                    end
                    checks++;
                    if ({refrig, portas, alarme} !== e.outs) begin
                        errors++;
                        $display("FAIL outputs at %0t: got %b expected %b", $time, {refrig, portas, alarme}, e.outs);
                    end
                    checks++;
                    if (votos !== e.votos) begin
                        errors++;
                        $display("FAIL votosAtivos at %0t: got %0d expected %0d", $time, votos, e.votos);
                    end
                end
            end
        end
    end

    initial begin
        bit           hot_mode;
        logic [N-1:0] rv;
        // Reset overrides sampling
        cyc(1, 1, 4'b1111, 0, 2);
        // Escalation ladder
        cyc(0, 1, 4'b0011, 0, 3);
        // Single vote and strobe-low holds
        cyc(1, 0, 4'b0000, 0, 1);
        cyc(0, 1, 4'b0001, 0, 10);
        cyc(0, 0, 4'b1111, 0, 10);
        // Latch, then acknowledge together with a hot sample
        cyc(0, 1, 4'b1111, 0, 3);
        cyc(0, 1, 4'b0000, 0, 20);
        cyc(0, 1, 4'b1111, 1, 1);
        // Ack ignored outside ALARME; then hysteresis back to rest
        cyc(0, 1, 4'b1111, 1, 2);
        cyc(0, 1, 4'b0000, 0, 12);
        // Broken cold streak does not de-escalate
        cyc(0, 1, 4'b0110, 0, 1);
        cyc(0, 1, 4'b0000, 0, 3);
        cyc(0, 1, 4'b0110, 0, 1);
        cyc(0, 1, 4'b0000, 0, 3);
        // Long hot streak while silenced, then release
        cyc(0, 1, 4'b1111, 0, 3);
        cyc(0, 0, 4'b0000, 1, 1);
        cyc(0, 1, 4'b1011, 0, 300);
        cyc(0, 1, 4'b0000, 0, 14);
        // Reset mid-alarm clears the hot streak
        cyc(0, 1, 4'b1111, 0, 3);
        cyc(1, 1, 4'b1111, 0, 1);
        cyc(0, 1, 4'b1111, 0, 1);
        cyc(0, 0, 4'b0000, 0, 1);
        // Randomized phases alternating hot- and cold-biased sensor patterns
        hot_mode = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (i % 40 == 0) hot_mode = ~hot_mode;
            rv = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) rv = hot_mode ? 4'b1111 : 4'b0000;
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), rv,
                ($urandom_range(0, 15) == 0), 1);
        end
        @(posedge clk);
        #2;
        done = 1'b1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
